// File: rtl/mon_frame_pkg.sv
// Shared types and constants for the monitor register-frame builder.
// Word layout: [26] type (1 = RdReg, 0 = AutoRead), [25:16] address, [15:0] value.
package mon_frame_pkg;

   localparam int WORD_W   = 27;
   localparam int TYPE_POS = 26;
   localparam int SLOT_W   = 26;
   localparam int FRAME_W  = 64;

   localparam logic [3:0] FRAME_STATUS = 4'h0;

   typedef enum logic [2:0] {
      IDLE,
      GAP_A,
      WAIT_B,
      GAP_B,
      SEND
   } state_t;

   // Header naming: first letter slot A, second slot B; A = AutoRead, R = RdReg.
   localparam logic [7:0] HDR_AA = 8'hB4;
   localparam logic [7:0] HDR_AR = 8'h55;
   localparam logic [7:0] HDR_RA = 8'h99;
   localparam logic [7:0] HDR_RR = 8'hD2;

   localparam logic [WORD_W-1:0] FILLER_WORD = {1'b0, 10'h3FF, 16'h0000};

   function automatic logic [7:0] frame_header(input logic type_a, input logic type_b);
      logic [7:0] hdr;
      case ({type_a, type_b})
         2'b00:   hdr = HDR_AA;
         2'b01:   hdr = HDR_AR;
         2'b10:   hdr = HDR_RA;
         default: hdr = HDR_RR;
      endcase
      return hdr;
   endfunction

   function automatic logic [FRAME_W-1:0] pack_frame(input logic [WORD_W-1:0] word_a,
                                                     input logic [WORD_W-1:0] word_b);
      return {frame_header(word_a[TYPE_POS], word_b[TYPE_POS]), FRAME_STATUS,
              word_a[SLOT_W-1:0], word_b[SLOT_W-1:0]};
   endfunction

endpackage

// File: rtl/mon_frame_builder.sv
// Drains the EOC monitor FIFO and packs word pairs into 64-bit register frames,
// padding a lone word with a filler slot after PadTimeout cycles.
module mon_frame_builder
   import mon_frame_pkg::*;
#(
   parameter int DataWidth  = 27,
   parameter int PadTimeout = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DataWidth-1:0] MonData,
   input  logic                 MonEmpty,
   output logic                 MonRead,
   output logic [63:0]          FrameData,
   output logic                 FrameValid,
   input  logic                 FrameReady,
   output logic [15:0]          FrameCnt,
   output logic [7:0]           PadCnt
);

   localparam logic [7:0] PAD_LAST = 8'(PadTimeout - 1);

   state_t              state;
   state_t              state_nxt;
   logic [7:0]          timer;
   logic [WORD_W-1:0]   word_a;
   logic [WORD_W-1:0]   word_b;
   logic [FRAME_W-1:0]  frame_data;
   logic [15:0]         frame_cnt;
   logic [7:0]          pad_cnt;

   logic pop;
   logic capture_a;
   logic capture_b;
   logic pad;
   logic timer_clr;
   logic timer_inc;
   logic load_frame;
   logic accept;

   // GAP states exist so MonEmpty is never looked at in the cycle after a pop,
   // when the FIFO's registered Empty still reflects the pre-pop count.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      capture_a  = 1'b0;
      capture_b  = 1'b0;
      pad        = 1'b0;
      timer_clr  = 1'b0;
      timer_inc  = 1'b0;
      load_frame = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (!MonEmpty) begin
               pop       = 1'b1;
               capture_a = 1'b1;
               state_nxt = GAP_A;
            end
         end
         GAP_A: begin
            timer_clr = 1'b1;
            state_nxt = WAIT_B;
         end
         WAIT_B: begin
            // A real word on the timeout cycle takes priority over padding.
            if (!MonEmpty) begin
               pop       = 1'b1;
               capture_b = 1'b1;
               state_nxt = GAP_B;
            end else if (timer == PAD_LAST) begin
               pad       = 1'b1;
               state_nxt = SEND;
            end else begin
               timer_inc = 1'b1;
            end
         end
         GAP_B: begin
            load_frame = 1'b1;
            state_nxt  = SEND;
         end
         SEND: begin
            if (FrameReady) begin
               accept    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         frame_data <= '0;
         frame_cnt  <= '0;
         pad_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (timer_clr) begin
            timer <= '0;
         end else if (timer_inc) begin
            timer <= timer + 8'd1;
         end
         if (load_frame || pad) begin
            frame_data <= pack_frame(word_a, pad ? FILLER_WORD : word_b);
         end
         if (accept) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (pad && (pad_cnt != 8'hFF)) begin
            pad_cnt <= pad_cnt + 8'd1;
         end
      end
   end

   // Captured words need no reset: a frame is only built after fresh captures.
   always_ff @(posedge clk) begin
      if (capture_a) begin
         word_a <= MonData[WORD_W-1:0];
      end
      if (capture_b) begin
         word_b <= MonData[WORD_W-1:0];
      end else if (pad) begin
         word_b <= FILLER_WORD;
      end
   end

   assign MonRead    = pop & ~reset;
   assign FrameValid = (state == SEND);
   assign FrameData  = frame_data;
   assign FrameCnt   = frame_cnt;
   assign PadCnt     = pad_cnt;

endmodule
